// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : Decode of LW/SW/ALUopI/ALUopR with bypassed register file,
//             load-use hazard detection and the ID/EX pipeline register.
//  Revision : 1.0
// ============================================================================
module id_ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        IFIDvalid,
   input  logic [31:0] IFIDinstr,
   input  logic [31:0] IFIDpc,
   input  logic        flush,
   input  logic        WBwe,
   input  logic [4:0]  WBrd,
   input  logic [31:0] WBdata,
   output logic        stall,
   output logic        IDEXvalid,
   output logic [6:0]  IDEXop,
   output logic [2:0]  IDEXfunct3,
   output logic [6:0]  IDEXfunct7,
   output logic [31:0] IDEXA,
   output logic [31:0] IDEXB,
   output logic [31:0] IDEXstoreData,
   output logic [4:0]  IDEXrd,
   output logic        IDEXregWrite,
   output logic        IDEXmemRead,
   output logic        IDEXmemWrite,
   output logic [31:0] IDEXpc,
   output logic        IDEXillegal
);

   localparam logic [6:0] c_op_lw  = 7'b0000011;
   localparam logic [6:0] c_op_sw  = 7'b0100011;
   localparam logic [6:0] c_op_alui = 7'b0010011;
   localparam logic [6:0] c_op_alur = 7'b0110011;

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   logic        idex_valid_q, idex_valid_d;
   logic [6:0]  idex_op_q, idex_op_d;
   logic [2:0]  idex_funct3_q, idex_funct3_d;
   logic [6:0]  idex_funct7_q, idex_funct7_d;
   logic [31:0] idex_a_q, idex_a_d;
   logic [31:0] idex_b_q, idex_b_d;
   logic [31:0] idex_store_q, idex_store_d;
   logic [4:0]  idex_rd_q, idex_rd_d;
   logic        idex_reg_write_q, idex_reg_write_d;
   logic        idex_mem_read_q, idex_mem_read_d;
   logic        idex_mem_write_q, idex_mem_write_d;
   logic [31:0] idex_pc_q, idex_pc_d;
   logic        idex_illegal_q, idex_illegal_d;

   logic [6:0]  w_op;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [31:0] w_imm_i, w_imm_s;
   logic [31:0] w_rs1_val, w_rs2_val;
   logic        w_legal, w_use_rs2, w_hazard;

   assign w_op     = IFIDinstr[6:0];
   assign w_rd     = IFIDinstr[11:7];
   assign w_funct3 = IFIDinstr[14:12];
   assign w_rs1    = IFIDinstr[19:15];
   assign w_rs2    = IFIDinstr[24:20];
   assign w_funct7 = IFIDinstr[31:25];
   assign w_imm_i  = {{20{IFIDinstr[31]}}, IFIDinstr[31:20]};
   assign w_imm_s  = {{20{IFIDinstr[31]}}, IFIDinstr[31:25], IFIDinstr[11:7]};

   // Write-back in the same cycle wins over the stored value.
   assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 :
                      (WBwe && (WBrd == w_rs1)) ? WBdata : regs_q[w_rs1];
   assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 :
                      (WBwe && (WBrd == w_rs2)) ? WBdata : regs_q[w_rs2];

   assign w_legal   = (w_op == c_op_lw) || (w_op == c_op_sw) ||
                      (w_op == c_op_alui) || (w_op == c_op_alur);
   assign w_use_rs2 = (w_op == c_op_alur) || (w_op == c_op_sw);

   assign w_hazard = IFIDvalid && !flush && idex_valid_q && idex_mem_read_q &&
                     (idex_rd_q != 5'd0) &&
                     ((w_legal && (idex_rd_q == w_rs1)) ||
                      (w_use_rs2 && (idex_rd_q == w_rs2)));
   assign stall    = w_hazard && !reset;

   always_comb begin
      regs_d = regs_q;
      if (WBwe && (WBrd != 5'd0)) begin
         regs_d[WBrd] = WBdata;
      end
   end

   always_comb begin
      idex_valid_d     = 1'b0;
      idex_op_d        = 7'd0;
      idex_funct3_d    = 3'd0;
      idex_funct7_d    = 7'd0;
      idex_a_d         = 32'd0;
      idex_b_d         = 32'd0;
      idex_store_d     = 32'd0;
      idex_rd_d        = 5'd0;
      idex_reg_write_d = 1'b0;
      idex_mem_read_d  = 1'b0;
      idex_mem_write_d = 1'b0;
      idex_pc_d        = 32'd0;
      idex_illegal_d   = 1'b0;
      if (IFIDvalid && !flush && !w_hazard) begin
         if (w_legal) begin
            idex_valid_d  = 1'b1;
            idex_op_d     = w_op;
            idex_funct3_d = w_funct3;
            idex_funct7_d = w_funct7;
            idex_a_d      = w_rs1_val;
            idex_pc_d     = IFIDpc;
         end
         case (w_op)
            c_op_alur: begin
               idex_reg_write_d = 1'b1;
               idex_rd_d        = w_rd;
               idex_b_d         = w_rs2_val;
            end
            c_op_alui: begin
               idex_reg_write_d = 1'b1;
               idex_rd_d        = w_rd;
               idex_b_d         = w_imm_i;
            end
            c_op_lw: begin
               idex_reg_write_d = 1'b1;
               idex_mem_read_d  = 1'b1;
               idex_rd_d        = w_rd;
               idex_b_d         = w_imm_i;
            end
            c_op_sw: begin
               idex_mem_write_d = 1'b1;
               idex_b_d         = w_imm_s;
               idex_store_d     = w_rs2_val;
            end
            default: idex_illegal_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'd0;
         end
         idex_valid_q     <= 1'b0;
         idex_op_q        <= 7'd0;
         idex_funct3_q    <= 3'd0;
         idex_funct7_q    <= 7'd0;
         idex_a_q         <= 32'd0;
         idex_b_q         <= 32'd0;
         idex_store_q     <= 32'd0;
         idex_rd_q        <= 5'd0;
         idex_reg_write_q <= 1'b0;
         idex_mem_read_q  <= 1'b0;
         idex_mem_write_q <= 1'b0;
         idex_pc_q        <= 32'd0;
         idex_illegal_q   <= 1'b0;
      end else begin
         regs_q           <= regs_d;
         idex_valid_q     <= idex_valid_d;
         idex_op_q        <= idex_op_d;
         idex_funct3_q    <= idex_funct3_d;
         idex_funct7_q    <= idex_funct7_d;
         idex_a_q         <= idex_a_d;
         idex_b_q         <= idex_b_d;
         idex_store_q     <= idex_store_d;
         idex_rd_q        <= idex_rd_d;
         idex_reg_write_q <= idex_reg_write_d;
         idex_mem_read_q  <= idex_mem_read_d;
         idex_mem_write_q <= idex_mem_write_d;
         idex_pc_q        <= idex_pc_d;
         idex_illegal_q   <= idex_illegal_d;
      end
   end

   assign IDEXvalid     = idex_valid_q;
   assign IDEXop        = idex_op_q;
   assign IDEXfunct3    = idex_funct3_q;
   assign IDEXfunct7    = idex_funct7_q;
   assign IDEXA         = idex_a_q;
   assign IDEXB         = idex_b_q;
   assign IDEXstoreData = idex_store_q;
   assign IDEXrd        = idex_rd_q;
   assign IDEXregWrite  = idex_reg_write_q;
   assign IDEXmemRead   = idex_mem_read_q;
   assign IDEXmemWrite  = idex_mem_write_q;
   assign IDEXpc        = idex_pc_q;
   assign IDEXillegal   = idex_illegal_q;

endmodule
`default_nettype wire
